// File: rtl/pid_actuator_conditioner.sv
// pid_actuator_conditioner: scales, clamps and rate-limits PID u(n) into a strobed 16-bit actuator command.
module pid_actuator_conditioner #(
  parameter int                 SHIFT    = 8,
  parameter logic signed [15:0] CMD_MAX  = 16'sh7FFF,
  parameter logic signed [15:0] CMD_MIN  = 16'sh8000,
  parameter int                 RATE_MAX = 256,
  parameter logic signed [15:0] CMD_INIT = 16'sh0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_un,
  input  logic        i_valid,
  input  logic        i_hold,
  output logic [15:0] o_cmd,
  output logic        o_cmd_stb,
  output logic        o_sat,
  output logic        o_rate_lim,
  output logic        o_busy,
  output logic        o_overrun
);
  typedef enum logic [1:0] {IDLE, CLAMP, RATE, UPDATE} state_t;
  localparam logic signed [31:0] MAX_X = {{16{CMD_MAX[15]}}, CMD_MAX};
  localparam logic signed [31:0] MIN_X = {{16{CMD_MIN[15]}}, CMD_MIN};
  localparam logic signed [16:0] R_POS = 17'(RATE_MAX);
  localparam logic signed [16:0] R_NEG = -R_POS;
  state_t state_q, state_d;
  logic valid_q, valid_d, stb_q, stb_d, sat_q, sat_d, rl_q, rl_d, ovr_q, ovr_d;
  logic c_q, c_d, r_q, r_d, rise;
  logic signed [31:0] s_q, s_d;
  logic signed [15:0] t_q, t_d, d_q, d_d, cmd_q, cmd_d;
  logic signed [16:0] diff;
  always_comb begin
    rise    = i_valid & ~valid_q;
    diff    = {t_q[15], t_q} - {cmd_q[15], cmd_q};
    valid_d = i_valid;
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    c_d     = c_q;
    d_d     = d_q;
    r_d     = r_q;
    cmd_d   = cmd_q;
    stb_d   = 1'b0;
    sat_d   = sat_q;
    rl_d    = rl_q;
    ovr_d   = ovr_q | (rise & (state_q != IDLE));
    case (state_q)
      IDLE: if (rise && !i_hold) begin
        s_d     = $signed(i_un) >>> SHIFT;
        state_d = CLAMP;
      end
      CLAMP: begin
        t_d     = s_q > MAX_X ? CMD_MAX : s_q < MIN_X ? CMD_MIN : s_q[15:0];
        c_d     = (s_q > MAX_X) | (s_q < MIN_X);
        state_d = RATE;
      end
      RATE: begin
        d_d     = diff > R_POS ? R_POS[15:0] : diff < R_NEG ? R_NEG[15:0] : diff[15:0];
        r_d     = (diff > R_POS) | (diff < R_NEG);
        state_d = UPDATE;
      end
      default: begin
        cmd_d   = cmd_q + d_q;
        stb_d   = 1'b1;
        sat_d   = c_q;
        rl_d    = r_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b1;
      s_q     <= '0;
      t_q     <= '0;
      c_q     <= 1'b0;
      d_q     <= '0;
      r_q     <= 1'b0;
      cmd_q   <= CMD_INIT;
      stb_q   <= 1'b0;
      sat_q   <= 1'b0;
      rl_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      t_q     <= t_d;
      c_q     <= c_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cmd_q   <= cmd_d;
      stb_q   <= stb_d;
      sat_q   <= sat_d;
      rl_q    <= rl_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_cmd      = cmd_q;
  assign o_cmd_stb  = stb_q;
  assign o_sat      = sat_q;
  assign o_rate_lim = rl_q;
  assign o_busy     = state_q != IDLE;
  assign o_overrun  = ovr_q;
endmodule
